// File: rtl/ita_job_scheduler.sv
// Job scheduler in front of the ITA controller: round-robin grant among requesters,
// then steps the granted job through its sequence, counting output tiles per step.
module ita_job_scheduler #(
  parameter int unsigned NumReq       = 2,
  parameter int unsigned IdWidth      = 4,
  parameter int unsigned TileCntWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0]              req_mode_i,
  input  logic [NumReq*TileCntWidth-1:0] req_tiles_i,
  input  logic [NumReq*IdWidth-1:0]      req_id_i,
  output logic [3:0]                     step_o,
  output logic                           step_valid_o,
  input  logic                           step_ready_i,
  input  logic                           tile_done_i,
  output logic [NumReq-1:0]              grant_o,
  output logic                           done_valid_o,
  input  logic                           done_ready_i,
  output logic [IdWidth-1:0]             done_id_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int unsigned PtrWidth = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam logic [3:0] StepIdle = 4'd0;
  localparam logic [3:0] StepQ    = 4'd1;
  localparam logic [3:0] StepOw   = 4'd6;
  localparam logic [3:0] StepF1   = 4'd7;
  localparam logic [3:0] StepF2   = 4'd8;

  // state | meaning
  // IDLE  | arbitrate and accept one job
  // ISSUE | offer step_o to the datapath until step_ready_i
  // RUN   | count tile_done_i pulses up to the job's tile budget
  // DONE  | present the completed job ID until done_ready_i
  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [PtrWidth-1:0]     ptr_q, ptr_d;
  logic [3:0]              step_q, step_d;
  logic [TileCntWidth-1:0] cnt_q, cnt_d;
  logic [TileCntWidth-1:0] tiles_q, tiles_d;
  logic [IdWidth-1:0]      id_q, id_d;
  logic [NumReq-1:0]       grant_q, grant_d;
  logic                    err_q;

  logic [TileCntWidth-1:0] tiles_arr [NumReq];
  logic [IdWidth-1:0]      id_arr    [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign tiles_arr[gi] = req_tiles_i[gi*TileCntWidth +: TileCntWidth];
    assign id_arr[gi]    = req_id_i[gi*IdWidth +: IdWidth];
  end

  logic                win_found;
  logic [PtrWidth-1:0] win_idx;
  int unsigned         cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = (32'(ptr_q) + i) % NumReq;
      if (!win_found && req_valid_i[PtrWidth'(cand)]) begin
        win_found = 1'b1;
        win_idx   = PtrWidth'(cand);
      end
    end
  end

  logic advance;
  logic last_step;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    tiles_d      = tiles_q;
    id_d         = id_q;
    grant_d      = grant_q;
    advance      = 1'b0;
    last_step    = (step_q == StepOw) || (step_q == StepF2);
    req_ready_o  = '0;
    step_valid_o = 1'b0;
    done_valid_o = 1'b0;
    done_id_o    = '0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          // ready is held low while reset is asserted so no requester sees a false accept
          if (rst_ni) req_ready_o[win_idx] = 1'b1;
          tiles_d          = tiles_arr[win_idx];
          id_d             = id_arr[win_idx];
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = PtrWidth'((32'(win_idx) + 1) % NumReq);
          step_d           = req_mode_i[win_idx] ? StepF1 : StepQ;
          state_d          = ISSUE;
        end
      end
      ISSUE: begin
        step_valid_o = 1'b1;
        if (step_ready_i) begin
          if (tiles_q == '0) begin
            advance = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (tile_done_i) begin
          if (cnt_q == tiles_q - TileCntWidth'(1)) begin
            cnt_d   = '0;
            advance = 1'b1;
          end else begin
            cnt_d = cnt_q + TileCntWidth'(1);
          end
        end
      end
      DONE: begin
        done_valid_o = 1'b1;
        done_id_o    = id_q;
        if (done_ready_i) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      if (last_step) begin
        step_d  = StepIdle;
        state_d = DONE;
      end else begin
        step_d  = step_q + 4'd1;
        state_d = ISSUE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      step_q  <= StepIdle;
      cnt_q   <= '0;
      tiles_q <= '0;
      id_q    <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      tiles_q <= tiles_d;
      id_q    <= id_d;
      grant_q <= grant_d;
      err_q   <= tile_done_i && (state_q != RUN);
    end
  end

  assign step_o  = step_q;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);
  assign err_o   = err_q;

endmodule

// File: tb/tb_ita_job_scheduler.sv
// Self-checking bench for ita_job_scheduler: scenario tasks driven against a
// job-level model (round-robin pointer, step sequences and tile budgets per job).
module tb_ita_job_scheduler;
  localparam int NumReq       = 2;
  localparam int IdWidth      = 4;
  localparam int TileCntWidth = 16;

  logic                           clk_i = 1'b0;
  logic                           rst_ni;
  logic [NumReq-1:0]              req_valid_i;
  logic [NumReq-1:0]              req_ready_o;
  logic [NumReq-1:0]              req_mode_i;
  logic [NumReq*TileCntWidth-1:0] req_tiles_i;
  logic [NumReq*IdWidth-1:0]      req_id_i;
  logic [3:0]                     step_o;
  logic                           step_valid_o;
  logic                           step_ready_i;
  logic                           tile_done_i;
  logic [NumReq-1:0]              grant_o;
  logic                           done_valid_o;
  logic                           done_ready_i;
  logic [IdWidth-1:0]             done_id_o;
  logic                           busy_o;
  logic                           err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int ptr_m   = 0;
  int mode_m  [NumReq];
  int tiles_m [NumReq];
  int id_m    [NumReq];

  always #5 clk_i = ~clk_i;

  ita_job_scheduler #(
    .NumReq(NumReq), .IdWidth(IdWidth), .TileCntWidth(TileCntWidth)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_mode_i(req_mode_i),
    .req_tiles_i(req_tiles_i), .req_id_i(req_id_i),
    .step_o(step_o), .step_valid_o(step_valid_o), .step_ready_i(step_ready_i),
    .tile_done_i(tile_done_i), .grant_o(grant_o),
    .done_valid_o(done_valid_o), .done_ready_i(done_ready_i), .done_id_o(done_id_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [NumReq-1:0] onehot(input int g);
    logic [NumReq-1:0] v;
    v = '0;
    v[g] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input logic [NumReq-1:0] v);
    for (int k = 0; k < NumReq; k++)
      if (v[(ptr_m + k) % NumReq]) return (ptr_m + k) % NumReq;
    return 0;
  endfunction

  task automatic submit(input int r, input int mode, input int tiles, input int id);
    mode_m[r]  = mode;
    tiles_m[r] = tiles;
    id_m[r]    = id;
    req_mode_i[r] = mode[0];
    req_tiles_i[r*TileCntWidth +: TileCntWidth] = tiles[TileCntWidth-1:0];
    req_id_i[r*IdWidth +: IdWidth] = id[IdWidth-1:0];
    req_valid_i[r] = 1'b1;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0;
    req_valid_i = '0;
    step_ready_i = 1'b0;
    tile_done_i = 1'b0;
    done_ready_i = 1'b0;
    ptr_m = 0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic accept(output int g);
    int waited;
    waited = 0;
    #1;
    g = rr_pick(req_valid_i);
    while (req_ready_o == '0 && waited < 20) begin
      tick();
      waited++;
    end
    n_tests++;
    if (req_ready_o !== onehot(g)) begin
      n_fail++;
      $display("FAIL accept_ready: got %b, exp %b", req_ready_o, onehot(g));
    end
    tick();
    req_valid_i[g] = 1'b0;
    ptr_m = (g + 1) % NumReq;
    n_tests++;
    if (busy_o !== 1'b1 || grant_o !== onehot(g)) begin
      n_fail++;
      $display("FAIL accept_grant: got busy=%b grant=%b, exp busy=1 grant=%b", busy_o, grant_o, onehot(g));
    end
  endtask

  task automatic run_job(input int g, input int rdy_max, input int gap_min, input int gap_max,
                         input int done_dly, input int stray_step);
    int seq[$];
    int d, gap;
    if (mode_m[g] == 0) seq = '{1, 2, 3, 4, 5, 6};
    else seq = '{7, 8};
    foreach (seq[i]) begin
      n_tests++;
      if (step_valid_o !== 1'b1 || step_o !== 4'(seq[i])) begin
        n_fail++;
        $display("FAIL step_issue: got valid=%b step=%0d, exp valid=1 step=%0d", step_valid_o, step_o, seq[i]);
      end
      d = (seq[i] == stray_step) ? 5 : $urandom_range(rdy_max, 0);
      for (int k = 0; k < d; k++) begin
        step_ready_i = 1'b0;
        tile_done_i = (seq[i] == stray_step && k == 1);
        tick();
        tile_done_i = 1'b0;
        n_tests++;
        if (step_valid_o !== 1'b1 || step_o !== 4'(seq[i]) || req_ready_o !== '0) begin
          n_fail++;
          $display("FAIL step_hold: got valid=%b step=%0d ready=%b, exp valid=1 step=%0d ready=0",
                   step_valid_o, step_o, req_ready_o, seq[i]);
        end
        n_tests++;
        if (err_o !== (seq[i] == stray_step && k == 1)) begin
          n_fail++;
          $display("FAIL err_pulse: got %b, exp %b", err_o, (seq[i] == stray_step && k == 1));
        end
      end
      step_ready_i = 1'b1;
      tick();
      step_ready_i = 1'b0;
      if (tiles_m[g] > 0) begin
        n_tests++;
        if (step_valid_o !== 1'b0 || err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL run_entry: got valid=%b err=%b, exp valid=0 err=0", step_valid_o, err_o);
        end
        for (int p = 0; p < tiles_m[g]; p++) begin
          gap = $urandom_range(gap_max, gap_min);
          for (int k = 0; k < gap; k++) begin
            tick();
            n_tests++;
            if (step_valid_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== '0) begin
              n_fail++;
              $display("FAIL run_hold: got valid=%b err=%b ready=%b, exp all 0", step_valid_o, err_o, req_ready_o);
            end
          end
          tile_done_i = 1'b1;
          tick();
          tile_done_i = 1'b0;
        end
      end
    end
    n_tests++;
    if (done_valid_o !== 1'b1 || done_id_o !== IdWidth'(id_m[g]) || step_o !== 4'd0 || grant_o !== onehot(g)) begin
      n_fail++;
      $display("FAIL done_present: got valid=%b id=%0d step=%0d grant=%b, exp valid=1 id=%0d step=0 grant=%b",
               done_valid_o, done_id_o, step_o, grant_o, id_m[g], onehot(g));
    end
    for (int k = 0; k < done_dly; k++) begin
      done_ready_i = 1'b0;
      tick();
      n_tests++;
      if (done_valid_o !== 1'b1 || done_id_o !== IdWidth'(id_m[g]) || grant_o !== onehot(g) || req_ready_o !== '0) begin
        n_fail++;
        $display("FAIL done_hold: got valid=%b id=%0d grant=%b ready=%b, exp valid=1 id=%0d grant=%b ready=0",
                 done_valid_o, done_id_o, grant_o, req_ready_o, id_m[g], onehot(g));
      end
    end
    done_ready_i = 1'b1;
    tick();
    done_ready_i = 1'b0;
    n_tests++;
    if (done_valid_o !== 1'b0 || busy_o !== 1'b0 || grant_o !== '0) begin
      n_fail++;
      $display("FAIL done_release: got valid=%b busy=%b grant=%b, exp 0/0/0", done_valid_o, busy_o, grant_o);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    rst_ni = 1'b0;
    tick();
    n_tests++;
    if ({step_o, step_valid_o, done_valid_o, done_id_o, grant_o, busy_o, err_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got step=%0d sv=%b dv=%b id=%0d grant=%b busy=%b err=%b ready=%b, exp all 0",
               step_o, step_valid_o, done_valid_o, done_id_o, grant_o, busy_o, err_o, req_ready_o);
    end
    rst_ni = 1'b1;
    tick();
    tile_done_i = 1'b1;
    tick();
    tile_done_i = 1'b0;
    n_tests++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_err: got %b, exp 1", err_o);
    end
    tick();
    n_tests++;
    if (err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_err_clear: got %b, exp 0", err_o);
    end
  endtask

  task automatic test_single_attention();
    int g;
    submit(0, 0, 3, 9);
    accept(g);
    run_job(g, 0, 1, 1, 0, 0);
  endtask

  task automatic test_back_to_back();
    int g;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      submit(0, 1, 1, 2 + rep);
      submit(1, 1, 1, 12 + rep);
      accept(g);
      run_job(g, 0, 0, 0, 0, 0);
      accept(g);
      run_job(g, 0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_step_ready_delay();
    int g;
    submit(0, 0, 1, 5);
    accept(g);
    run_job(g, 0, 0, 0, 0, 2);
  endtask

  task automatic test_zero_tiles();
    int g;
    submit(1, 0, 0, 7);
    accept(g);
    run_job(g, 0, 0, 0, 0, 0);
  endtask

  task automatic test_done_backpressure();
    int g;
    submit(0, 1, 1, 3);
    accept(g);
    submit(1, 0, 1, 11);
    run_job(g, 0, 0, 1, 4, 0);
    n_tests++;
    if (req_ready_o !== onehot(1)) begin
      n_fail++;
      $display("FAIL pending_ready: got %b, exp %b", req_ready_o, onehot(1));
    end
    accept(g);
    run_job(g, 1, 0, 1, 1, 0);
  endtask

  task automatic test_random();
    int g;
    for (int j = 0; j < 12; j++) begin
      for (int r = 0; r < NumReq; r++)
        if (!req_valid_i[r] && $urandom_range(1, 0) == 1)
          submit(r, $urandom_range(1, 0), $urandom_range(4, 0), $urandom_range(15, 0));
      if (req_valid_i == '0)
        submit($urandom_range(NumReq - 1, 0), $urandom_range(1, 0), $urandom_range(4, 0), $urandom_range(15, 0));
      accept(g);
      run_job(g, 3, 0, 2, $urandom_range(2, 0), 0);
    end
    while (req_valid_i != '0) begin
      accept(g);
      run_job(g, 1, 0, 1, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    int g;
    submit(0, 0, 5, 6);
    accept(g);
    for (int s = 1; s <= 4; s++) begin
      n_tests++;
      if (step_valid_o !== 1'b1 || step_o !== 4'(s)) begin
        n_fail++;
        $display("FAIL mid_issue: got valid=%b step=%0d, exp valid=1 step=%0d", step_valid_o, step_o, s);
      end
      step_ready_i = 1'b1;
      tick();
      step_ready_i = 1'b0;
      for (int p = 0; p < ((s == 4) ? 2 : 5); p++) begin
        tile_done_i = 1'b1;
        tick();
        tile_done_i = 1'b0;
      end
    end
    #2 rst_ni = 1'b0;
    #1;
    n_tests++;
    if ({step_o, step_valid_o, done_valid_o, done_id_o, grant_o, busy_o, err_o, req_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got step=%0d sv=%b dv=%b id=%0d grant=%b busy=%b err=%b ready=%b, exp all 0",
               step_o, step_valid_o, done_valid_o, done_id_o, grant_o, busy_o, err_o, req_ready_o);
    end
    ptr_m = 0;
    tick();
    rst_ni = 1'b1;
    tick();
    submit(0, 1, 2, 1);
    submit(1, 0, 3, 14);
    accept(g);
    n_tests++;
    if (g !== 0) begin
      n_fail++;
      $display("FAIL ptr_after_reset: got winner %0d, exp 0", g);
    end
    run_job(g, 0, 0, 1, 0, 0);
    accept(g);
    run_job(g, 0, 0, 1, 0, 0);
  endtask

  initial begin
    rst_ni       = 1'b0;
    req_valid_i  = '0;
    req_mode_i   = '0;
    req_tiles_i  = '0;
    req_id_i     = '0;
    step_ready_i = 1'b0;
    tile_done_i  = 1'b0;
    done_ready_i = 1'b0;
    test_reset();
    test_single_attention();
    test_back_to_back();
    test_step_ready_delay();
    test_zero_tiles();
    test_done_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
